// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter and write sequencer for one shared register.
// Ports: clk, rst, req, wr_en, wdata in; gnt, busy, owner, q, q_valid, wr_done out.
module shared_reg_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = 8,
  parameter int HOLD_MAX = 4,
  localparam int OWN_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        wr_en,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      busy,
  output logic [OWN_W-1:0]          owner,
  output logic [DATA_W-1:0]         q,
  output logic                      q_valid,
  output logic                      wr_done
);

  localparam int HC_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [HC_W-1:0] HC_LAST = HC_W'(HOLD_MAX - 1);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t              state, state_n;
  logic [NUM_REQ-1:0]  gnt_n;
  logic [OWN_W-1:0]    owner_n;
  logic [OWN_W-1:0]    ptr, ptr_n;
  logic [HC_W-1:0]     hold_cnt, hold_n;
  logic [DATA_W-1:0]   q_n;
  logic                qv_n;
  logic                wd_n;

  logic                found;
  logic [OWN_W-1:0]    pick;
  int                  idx;

  // Rotating search starting at ptr; first requester found wins.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx[OWN_W-1:0]]) begin
        found = 1'b1;
        pick  = idx[OWN_W-1:0];
      end
    end
  end

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    owner_n = owner;
    ptr_n   = ptr;
    hold_n  = hold_cnt;
    q_n     = q;
    qv_n    = q_valid;
    wd_n    = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) begin
          gnt_n       = '0;
          gnt_n[pick] = 1'b1;
          owner_n     = pick;
          hold_n      = '0;
          state_n     = GRANT;
        end
      end
      GRANT: begin
        // Owner's write lands even in the release cycle.
        if (wr_en[owner]) begin
          q_n  = wdata[int'(owner)*DATA_W +: DATA_W];
          qv_n = 1'b1;
          wd_n = 1'b1;
        end
        if (!req[owner] || hold_cnt == HC_LAST) begin
          gnt_n   = '0;
          state_n = IDLE;
          ptr_n   = (owner == OWN_W'(NUM_REQ - 1)) ?
                    '0 : owner + 1'b1;
        end else begin
          hold_n = hold_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      owner    <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
      q        <= '0;
      q_valid  <= 1'b0;
      wr_done  <= 1'b0;
    end else begin
      state    <= state_n;
      gnt      <= gnt_n;
      owner    <= owner_n;
      ptr      <= ptr_n;
      hold_cnt <= hold_n;
      q        <= q_n;
      q_valid  <= qv_n;
      wr_done  <= wd_n;
    end
  end

  assign busy = (state == GRANT);

endmodule
